// File: rtl/board_loader.sv
// Snapshots a selected 9x9 solution map plus visibility vector and streams it
// cell by cell (row-major) into the board register file, then pulses map_loaded.
module board_loader #(
  parameter int CELLS   = 81,
  parameter int VALUE_W = 4,
  parameter int VIS_W   = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [CELLS*VALUE_W-1:0]   selected_map,
  input  logic [CELLS*VIS_W-1:0]     selected_visibility,
  output logic                       wr_en,
  output logic [3:0]                 wr_row,
  output logic [3:0]                 wr_col,
  output logic [VALUE_W-1:0]         wr_value,
  output logic [VIS_W-1:0]           wr_vis,
  output logic                       busy,
  output logic                       map_loaded,
  output logic [6:0]                 given_count,
  output logic                       value_error
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [6:0]         LAST_IDX = 7'(CELLS - 1);
  localparam logic [VALUE_W-1:0] MAX_VAL  = VALUE_W'(9);

  logic [1:0]               state_q, state_d;
  logic [CELLS*VALUE_W-1:0] map_q, map_d;
  logic [CELLS*VIS_W-1:0]   vis_q, vis_d;
  logic [6:0]               idx_q, idx_d;
  logic [3:0]               row_q, row_d;
  logic [3:0]               col_q, col_d;
  logic                     wr_en_q, wr_en_d;
  logic [3:0]               wr_row_q, wr_row_d;
  logic [3:0]               wr_col_q, wr_col_d;
  logic [VALUE_W-1:0]       wr_value_q, wr_value_d;
  logic [VIS_W-1:0]         wr_vis_q, wr_vis_d;
  logic                     busy_q, busy_d;
  logic                     map_loaded_q, map_loaded_d;
  logic [6:0]               given_q, given_d;
  logic                     verr_q, verr_d;

  logic [CELLS*VALUE_W-1:0] map_sh;
  logic [CELLS*VIS_W-1:0]   vis_sh;
  logic [VALUE_W-1:0]       cur_val;
  logic [VIS_W-1:0]         cur_vis;

  // Current cell is selected by shifting the snapshot down by idx cells.
  assign map_sh  = map_q >> (int'(idx_q) * VALUE_W);
  assign vis_sh  = vis_q >> (int'(idx_q) * VIS_W);
  assign cur_val = map_sh[VALUE_W-1:0];
  assign cur_vis = vis_sh[VIS_W-1:0];

  always_comb begin
    state_d      = state_q;
    map_d        = map_q;
    vis_d        = vis_q;
    idx_d        = idx_q;
    row_d        = row_q;
    col_d        = col_q;
    wr_en_d      = 1'b0;
    wr_row_d     = wr_row_q;
    wr_col_d     = wr_col_q;
    wr_value_d   = wr_value_q;
    wr_vis_d     = wr_vis_q;
    busy_d       = busy_q;
    map_loaded_d = 1'b0;
    given_d      = given_q;
    verr_d       = verr_q;
    case (state_q)
      S_IDLE: begin
        busy_d = start;
        if (start) begin
          map_d   = selected_map;
          vis_d   = selected_visibility;
          given_d = '0;
          verr_d  = 1'b0;
          idx_d   = '0;
          row_d   = '0;
          col_d   = '0;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        wr_en_d    = 1'b1;
        wr_row_d   = row_q;
        wr_col_d   = col_q;
        wr_value_d = cur_val;
        wr_vis_d   = cur_vis;
        if (cur_vis != '0) given_d = given_q + 7'd1;
        // Illegal values are flagged but still written through.
        if (cur_val == '0 || cur_val > MAX_VAL) verr_d = 1'b1;
        idx_d = idx_q + 7'd1;
        if (col_q == 4'd8) begin
          col_d = '0;
          row_d = row_q + 4'd1;
        end else begin
          col_d = col_q + 4'd1;
        end
        if (idx_q == LAST_IDX) state_d = S_DONE;
      end
      S_DONE: begin
        // Back to IDLE here so a held start restarts on the very next edge.
        map_loaded_d = 1'b1;
        state_d      = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      map_q        <= '0;
      vis_q        <= '0;
      idx_q        <= '0;
      row_q        <= '0;
      col_q        <= '0;
      wr_en_q      <= 1'b0;
      wr_row_q     <= '0;
      wr_col_q     <= '0;
      wr_value_q   <= '0;
      wr_vis_q     <= '0;
      busy_q       <= 1'b0;
      map_loaded_q <= 1'b0;
      given_q      <= '0;
      verr_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      map_q        <= map_d;
      vis_q        <= vis_d;
      idx_q        <= idx_d;
      row_q        <= row_d;
      col_q        <= col_d;
      wr_en_q      <= wr_en_d;
      wr_row_q     <= wr_row_d;
      wr_col_q     <= wr_col_d;
      wr_value_q   <= wr_value_d;
      wr_vis_q     <= wr_vis_d;
      busy_q       <= busy_d;
      map_loaded_q <= map_loaded_d;
      given_q      <= given_d;
      verr_q       <= verr_d;
    end
  end

  assign wr_en       = wr_en_q;
  assign wr_row      = wr_row_q;
  assign wr_col      = wr_col_q;
  assign wr_value    = wr_value_q;
  assign wr_vis      = wr_vis_q;
  assign busy        = busy_q;
  assign map_loaded  = map_loaded_q;
  assign given_count = given_q;
  assign value_error = verr_q;

endmodule

// File: tb/tb_board_loader.sv
// Randomized bench for board_loader, checked every cycle against a
// cycle-offset reference model (write j of a load lands j edges after accept).
module tb_board_loader;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [323:0] selected_map;
  logic [161:0] selected_visibility;
  logic         wr_en;
  logic [3:0]   wr_row, wr_col, wr_value;
  logic [1:0]   wr_vis;
  logic         busy, map_loaded;
  logic [6:0]   given_count;
  logic         value_error;

  board_loader dut (
    .clk                 (clk),
    .reset               (reset),
    .start               (start),
    .selected_map        (selected_map),
    .selected_visibility (selected_visibility),
    .wr_en               (wr_en),
    .wr_row              (wr_row),
    .wr_col              (wr_col),
    .wr_value            (wr_value),
    .wr_vis              (wr_vis),
    .busy                (busy),
    .map_loaded          (map_loaded),
    .given_count         (given_count),
    .value_error         (value_error)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  bit         m_act = 1'b0;
  int         m_j   = 0;
  int         m_loads = 0;
  logic [3:0] s_val [81];
  logic [1:0] s_vis [81];
  logic       e_wr_en = 1'b0, e_ml = 1'b0, e_busy = 1'b0, e_verr = 1'b0;
  logic [3:0] e_row = '0, e_col = '0, e_val = '0;
  logic [1:0] e_vis = '0;
  logic [6:0] e_given = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge();
    int c;
    if (reset) begin
      m_act = 1'b0; e_wr_en = 1'b0; e_ml = 1'b0; e_busy = 1'b0; e_verr = 1'b0;
      e_row = '0; e_col = '0; e_val = '0; e_vis = '0; e_given = '0;
    end else if (m_act) begin
      m_j++;
      if (m_j <= 81) begin
        c = m_j - 1;
        e_wr_en = 1'b1;
        e_row   = 4'(c / 9);
        e_col   = 4'(c % 9);
        e_val   = s_val[c];
        e_vis   = s_vis[c];
        if (e_vis != 2'b00) e_given = e_given + 7'd1;
        if (e_val == 4'd0 || e_val > 4'd9) e_verr = 1'b1;
        e_busy = 1'b1;
        e_ml   = 1'b0;
      end else begin
        e_wr_en = 1'b0;
        e_ml    = 1'b1;
        e_busy  = 1'b1;
        m_act   = 1'b0;
        m_loads++;
      end
    end else begin
      e_wr_en = 1'b0;
      e_ml    = 1'b0;
      if (start) begin
        for (int i = 0; i < 81; i++) begin
          s_val[i] = selected_map[i*4 +: 4];
          s_vis[i] = selected_visibility[i*2 +: 2];
        end
        e_given = '0;
        e_verr  = 1'b0;
        m_act   = 1'b1;
        m_j     = 0;
        e_busy  = 1'b1;
      end else begin
        e_busy = 1'b0;
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    chk("wr_en",       32'(wr_en),       32'(e_wr_en));
    chk("wr_row",      32'(wr_row),      32'(e_row));
    chk("wr_col",      32'(wr_col),      32'(e_col));
    chk("wr_value",    32'(wr_value),    32'(e_val));
    chk("wr_vis",      32'(wr_vis),      32'(e_vis));
    chk("busy",        32'(busy),        32'(e_busy));
    chk("map_loaded",  32'(map_loaded),  32'(e_ml));
    chk("given_count", 32'(given_count), 32'(e_given));
    chk("value_error", 32'(value_error), 32'(e_verr));
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) cycle();
  endtask

  task automatic rand_inputs(input bit legal);
    for (int i = 0; i < 81; i++) begin
      selected_map[i*4 +: 4] = legal ? 4'($urandom_range(1, 9)) : 4'($urandom_range(0, 15));
      selected_visibility[i*2 +: 2] = 2'($urandom_range(0, 3));
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cycle();
    start = 1'b0;
  endtask

  int loads_before;

  initial begin
    reset = 1'b1;
    start = 1'b0;
    selected_map = '0;
    selected_visibility = '0;
    run(3);
    reset = 1'b0;
    run(10);

    // Counting pattern, every cell visible
    for (int i = 0; i < 81; i++) begin
      selected_map[i*4 +: 4] = 4'((i % 9) + 1);
      selected_visibility[i*2 +: 2] = 2'b01;
    end
    pulse_start();
    run(85);
    chk("given_full", 32'(given_count), 32'd81);
    chk("last_value", 32'(wr_value), 32'd9);

    // Only cells 0, 40, 80 visible
    rand_inputs(1'b1);
    selected_visibility = '0;
    selected_visibility[0*2 +: 2]  = 2'b10;
    selected_visibility[40*2 +: 2] = 2'b01;
    selected_visibility[80*2 +: 2] = 2'b11;
    pulse_start();
    run(85);
    chk("given_three", 32'(given_count), 32'd3);

    // Illegal values at cells 17 and 50, then a clean load
    rand_inputs(1'b1);
    selected_map[17*4 +: 4] = 4'h0;
    selected_map[50*4 +: 4] = 4'hF;
    pulse_start();
    run(85);
    chk("verr_sticky", 32'(value_error), 32'd1);
    rand_inputs(1'b1);
    pulse_start();
    run(85);
    chk("verr_cleared", 32'(value_error), 32'd0);

    // Inputs scrambled every cycle and a stray start mid-load
    rand_inputs(1'b0);
    loads_before = m_loads;
    pulse_start();
    for (int k = 0; k < 90; k++) begin
      rand_inputs(1'b0);
      start = (k == 40);
      cycle();
    end
    start = 1'b0;
    chk("single_load", 32'(m_loads - loads_before), 32'd1);

    // Reset at the 30th write, then a full clean load
    rand_inputs(1'b1);
    pulse_start();
    while (m_j < 30) cycle();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    run(5);
    rand_inputs(1'b1);
    pulse_start();
    run(85);

    // Start held high: back-to-back loads
    rand_inputs(1'b0);
    start = 1'b1;
    run(200);
    start = 1'b0;
    run(90);

    // Random traffic
    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(0, 3) == 0) rand_inputs($urandom_range(0, 1) == 1);
      start = ($urandom_range(0, 29) == 0);
      reset = ($urandom_range(0, 399) == 0);
      cycle();
    end
    start = 1'b0;
    reset = 1'b0;
    run(90);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/board_loader.md
Name: board_loader

Overview:
- Downstream of the map selector.
- Takes one snapshot of the selected 324-bit solution map and 162-bit visibility vector, then streams it cell by cell (81 cells, row-major) into the game board register file over a write port.
- Returns the one-cycle `map_loaded` pulse that advances the random map index.
- Also reports the number of visible (given) cells and flags illegal cell values.

Parameters:
- CELLS, 81, cells per board (9x9); only 81 supported.
- VALUE_W, 4, bits per cell value in the map vector.
- VIS_W, 2, bits per cell in the visibility vector.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request a load; sampled only in IDLE.
- selected_map  input  324  cell i value at [i*4 +: 4], i = row*9+col.
- selected_visibility  input  162  cell i visibility at [i*2 +: 2].
- wr_en  output  1  board write strobe.
- wr_row  output  4  row 0..8 of the current write.
- wr_col  output  4  column 0..8 of the current write.
- wr_value  output  4  cell value.
- wr_vis  output  2  cell visibility code.
- busy  output  1  high from accept until `map_loaded` inclusive.
- map_loaded  output  1  one-cycle pulse after the last write.
- given_count  output  7  count of cells with vis != 2'b00 in the last load.
- value_error  output  1  sticky; some cell value was outside 1..9 during the last load.

Behaviour:
- Synchronous active-high reset, priority over everything.
  - State = IDLE.
  - All outputs 0, including `given_count` and `value_error`.
  - Internal snapshot, index, row and col counters = 0.
- States: IDLE, LOAD, DONE.
- IDLE:
  - `start`=1 at edge T: copy `selected_map` and `selected_visibility` into internal shadow registers.
  - Clear `given_count` and `value_error`; set idx=0, row=0, col=0; go to LOAD.
  - `busy`=1 from T onward.
  - Input vectors are ignored after edge T; changes to them do not affect the load in progress.
- LOAD (registered outputs):
  - Each edge drives `wr_en`=1, `wr_row`/`wr_col` = current row/col, `wr_value` = shadow[idx*4 +: 4], `wr_vis` = shadow_vis[idx*2 +: 2].
  - Then idx++; col++, wrapping 8->0 with row++.
  - Row and col are kept as counters, not derived by division.
  - `wr_en` is high for exactly 81 consecutive cycles, T+1 through T+81, cells in order (0,0),(0,1)..(0,8),(1,0)..(8,8).
  - `given_count` increments in the same edge for each written cell whose vis != 0. It never exceeds 81.
  - `value_error` sets when a written value is 0 or >9. The cell is still written.
  - At edge T+81, the cell (8,8) write is issued: go to DONE.
- DONE:
  - At edge T+82: `wr_en`=0, `map_loaded`=1 for one cycle, `busy` still 1.
  - Next edge: `map_loaded`=0, `busy`=0, go to IDLE.
- Held outputs: `wr_row`/`wr_col`/`wr_value`/`wr_vis` hold their last value when `wr_en`=0. The consumer must qualify them with `wr_en`.
- `given_count` and `value_error` hold until the next accepted `start` or reset.
- `start` while `busy`: ignored, not queued. `start` held high continuously restarts a load every 83 cycles.
- Reset during LOAD/DONE: abort immediately; no further writes; no `map_loaded` pulse.
- Latency: `start` sampled at edge T gives the first write valid after T+1 and `map_loaded` high after T+82.

Test Plan:
- Reset then idle 10 cycles -> all outputs 0, `wr_en` never asserted.
- Map with cell i value = (i%9)+1, all vis=2'b01, pulse `start` -> 81 writes in row-major order, writes 9 at (8,8), `given_count`=81, `value_error`=0, `map_loaded` exactly 82 cycles after `start`, one cycle wide.
- Vis nonzero only for cells 0, 40, 80 -> `given_count`=3, `wr_vis` matches per cell.
- Cell 17 value=0, cell 50 value=4'hF -> `value_error`=1 after write 17 and remains 1, all 81 writes still occur; next clean load clears it.
- Change `selected_map` every cycle during LOAD and pulse `start` mid-load -> written data equals the snapshot at accept, no restart, single `map_loaded`.
- Assert reset at the 30th write -> no further `wr_en`, no `map_loaded`, outputs 0; a subsequent `start` performs a full clean 81-write load.
